instr_fetch_unit: RTL and testbench

- Fetch-stage producer that feeds the decode-stage hazard/forwarding controller.
- Generates the PC, issues in-order instruction-memory requests, buffers responses, and presents `instruction` plus a one-ahead `next_instruction` peek.
- Honours the controller's `f_to_d_enable_ff` stall and the execute-stage redirect (taken branch/jump) by flushing in-flight and buffered instructions.

---
 rtl/riscv_pipe_pkg.sv | 28 ++
 rtl/fetch_buffer.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types and constants for the RISC-V front-end pipeline.
//   NOP_INSTR     - canonical bubble (addi x0, x0, 0)
//   OP_*          - major opcode constants used by decode-side consumers
//   fetch_state_t - fetch-unit control state
//   fetch_entry_t - one buffered fetch result {pc, instr}
package riscv_pipe_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch_entry_t used as the fetch prefetch buffer.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clear           - drop all entries; wins over a same-cycle push/pop
//   push/push_entry - write one entry (ignored when full unless a pop frees a slot)
//   pop             - retire the head entry (ignored when empty)
//   head            - combinational view of the oldest entry
//   count/not_empty - occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok    = pop && (count != '0);
  assign push_ok   = push && ((count != CNT_W'(DEPTH)) || pop_ok);
  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the decode hazard/forwarding controller.
// Generates the PC, issues in-order instruction-memory requests under a credit
// limit of BUF_DEPTH (outstanding + buffered), buffers responses, and presents a
// registered instruction plus a combinational one-ahead peek of the buffer head.
// A redirect flushes the buffer and discards every still-outstanding response.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   f_to_d_enable_ff                  - 1: decode takes an instruction; 0: hold outputs
//   redirect_valid, redirect_pc       - taken branch/jump restart address
//   imem_req_valid/ready/addr         - instruction-memory request channel
//   imem_rsp_valid/data               - in-order responses, no backpressure
//   instruction/_valid/_pc            - decode register
//   next_instruction, next_valid      - buffer head peek (NOP when empty)
// Optional build macro IFU_PERF_COUNTERS_EN adds saturating counters
//   perf_stall_cycles, perf_bubbles, perf_flushes.
// XLEN must not exceed the package PC width (64).
module instr_fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter int               XLEN               = 64,
  parameter int               INSTRUCTION_LENGTH = 32,
  parameter logic [XLEN-1:0]  RESET_PC           = '0,
  parameter int               BUF_DEPTH          = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          f_to_d_enable_ff,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] imem_rsp_data,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic                          instruction_valid,
  output logic [XLEN-1:0]               instruction_pc,
  output logic [INSTRUCTION_LENGTH-1:0] next_instruction,
  output logic                          next_valid
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_bubbles,
  output logic [31:0]                   perf_flushes
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [XLEN-1:0]  redirect_base;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] drop_d;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   inflight;
  logic             req_fire;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             buf_valid;
  logic             buf_pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic             unused_redirect_lsbs;

  assign redirect_base        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit rule: never have more requests in flight plus entries buffered than
  // the buffer can hold, so a response can always be accepted.
  assign inflight       = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = (state_q != IDLE) && (inflight < (CNT_W+1)'(BUF_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_count != '0);
  assign rsp_keep = imem_rsp_valid && (drop_count == '0);

  // rsp_pc tracks the address of the next response that will be kept, since
  // responses return strictly in request order.
  assign push_entry.pc    = PC_W'(rsp_pc);
  assign push_entry.instr = INSTR_W'(imem_rsp_data);
  assign buf_pop          = f_to_d_enable_ff && !redirect_valid;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .push       (rsp_keep),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .head       (head),
    .count      (buf_count),
    .not_empty  (buf_valid)
  );

  assign next_valid       = buf_valid;
  assign next_instruction = buf_valid ? INSTRUCTION_LENGTH'(head.instr)
                                      : INSTRUCTION_LENGTH'(NOP_INSTR);

  always_comb begin
    state_d = state_q;
    drop_d  = drop_count;
    if (rsp_drop) drop_d = drop_count - CNT_W'(1);
    case (state_q)
      IDLE:    state_d = RUN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = state_q;
    endcase
    // Everything still outstanding after this cycle is stale, including any
    // response counted during an earlier drain and any arriving right now.
    if (redirect_valid) begin
      drop_d  = outstanding - CNT_W'(imem_rsp_valid);
      state_d = (drop_d != '0) ? DRAIN : RUN;
    end
  end

  // Control: state, PCs, request/drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_d;
      drop_count  <= drop_d;
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_keep) rsp_pc   <= rsp_pc + XLEN'(4);
      end
    end
  end

  // Decode register: the PC is left unchanged when a bubble is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction       <= INSTRUCTION_LENGTH'(NOP_INSTR);
      instruction_valid <= 1'b0;
      instruction_pc    <= '0;
    end else if (redirect_valid) begin
      instruction       <= INSTRUCTION_LENGTH'(NOP_INSTR);
      instruction_valid <= 1'b0;
    end else if (f_to_d_enable_ff) begin
      if (buf_valid) begin
        instruction       <= INSTRUCTION_LENGTH'(head.instr);
        instruction_valid <= 1'b1;
        instruction_pc    <= XLEN'(head.pc);
      end else begin
        instruction       <= INSTRUCTION_LENGTH'(NOP_INSTR);
        instruction_valid <= 1'b0;
      end
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else begin
      if (!f_to_d_enable_ff) perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (f_to_d_enable_ff && !buf_valid && !redirect_valid) perf_bubbles <= sat_inc(perf_bubbles);
      if (redirect_valid) perf_flushes <= sat_inc(perf_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench for instr_fetch_unit with a single-cycle (holdable)
// instruction memory and a transaction-level reference model built on queues.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_to_d_enable_ff;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic [63:0] instruction_pc;
  logic [31:0] next_instruction;
  logic        next_valid;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN(64), .INSTRUCTION_LENGTH(32), .RESET_PC(64'h1000), .BUF_DEPTH(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .f_to_d_enable_ff  (f_to_d_enable_ff),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .instruction_pc    (instruction_pc),
    .next_instruction  (next_instruction),
    .next_valid        (next_valid)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = idle, 1 = run, 2 = drain
  int          m_state;
  int          m_out;
  int          m_drop;
  logic [63:0] m_fpc;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [63:0] q_pc[$];
  logic [31:0] q_in[$];
  logic [63:0] pend[$];   // memory: accepted, not yet answered

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'hCAFE0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_out = 0; m_drop = 0;
    m_fpc = 64'h1000; m_ipc = 64'h0; m_instr = NOP; m_valid = 1'b0;
    q_pc.delete(); q_in.delete();
  endtask

  task automatic tick(input logic r, input logic en, input logic rdy, input logic rv,
                      input logic [63:0] rpc, input logic hold);
    logic        exp_req;
    logic        rsp_v;
    logic [63:0] rsp_a;
    logic [31:0] rsp_d;
    @(negedge clk);
    rst = r; f_to_d_enable_ff = en; imem_req_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;
    rsp_v = 1'b0; rsp_a = 64'h0;
    if (!r && !hold && pend.size() > 0) begin
      rsp_v = 1'b1;
      rsp_a = pend.pop_front();
    end
    rsp_d = mem_data(rsp_a);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? rsp_d : 32'hDEADBEEF;
    #1;
    exp_req = (m_state != 0) && (m_out + q_pc.size() < 2) && !rv;
    chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, m_fpc);
    chk("instruction", 64'(instruction), 64'(m_instr));
    chk("instruction_valid", 64'(instruction_valid), 64'(m_valid));
    if (m_valid) chk("instruction_pc", instruction_pc, m_ipc);
    chk("next_valid", 64'(next_valid), 64'(q_pc.size() > 0));
    chk("next_instruction", 64'(next_instruction), 64'(q_in.size() > 0 ? q_in[0] : NOP));
    if (r) begin
      pend.delete();
      model_reset();
    end else begin
      if (imem_req_valid && rdy) pend.push_back(imem_req_addr);
      if (rv) begin
        if (rsp_v) m_out--;
        m_drop = m_out;
        q_pc.delete(); q_in.delete();
        m_fpc = {rpc[63:2], 2'b00};
        m_instr = NOP; m_valid = 1'b0;
        m_state = (m_drop > 0) ? 2 : 1;
      end else begin
        if (en) begin
          if (q_pc.size() > 0) begin
            m_instr = q_in.pop_front(); m_ipc = q_pc.pop_front(); m_valid = 1'b1;
          end else begin
            m_instr = NOP; m_valid = 1'b0;
          end
        end
        if (rsp_v) begin
          m_out--;
          if (m_drop > 0) m_drop--;
          else begin
            q_pc.push_back(rsp_a); q_in.push_back(rsp_d);
          end
        end
        if (exp_req && rdy) begin
          m_out++; m_fpc = m_fpc + 64'd4;
        end
        if (m_state == 0) m_state = 1;
        else if (m_state == 2 && m_drop == 0) m_state = 1;
      end
    end
  endtask

  task automatic run(input int n, input logic en, input logic rdy, input logic hold);
    for (int i = 0; i < n; i++) tick(1'b0, en, rdy, 1'b0, 64'h0, hold);
  endtask

  // Run until the first valid instruction and compare its pc to a literal.
  task automatic expect_first_pc(input string nm, input logic [63:0] pc);
    bit seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      if (instruction_valid) begin
        seen = 1;
        chk(nm, instruction_pc, pc);
        chk({nm, "_data"}, 64'(instruction), 64'(mem_data(pc)));
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic expect_first_req(input string nm, input logic [63:0] addr);
    bit seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      if (imem_req_valid) begin
        seen = 1;
        chk(nm, imem_req_addr, addr);
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1; f_to_d_enable_ff = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    model_reset();
    @(posedge clk);

    // Reset state
    tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("rst_instruction", 64'(instruction), 64'(NOP));
    chk("rst_valid", 64'(instruction_valid), 64'd0);
    chk("rst_pc", instruction_pc, 64'h0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);

    // Startup: IDLE cycle, then requests from 0x1000
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("idle_no_req", 64'(imem_req_valid), 64'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("first_req", imem_req_addr, 64'h1000);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("second_req", imem_req_addr, 64'h1004);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("peek_first", 64'(next_instruction), 64'h00000000CAFE1000);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("first_valid", 64'(instruction_valid), 64'd1);
    chk("first_pc", instruction_pc, 64'h1000);
    run(10, 1'b1, 1'b1, 1'b0);

    // Decode stall for 3 cycles: buffer fills, requests stop
    run(3, 1'b0, 1'b1, 1'b0);
    chk("stall_no_req", 64'(imem_req_valid), 64'd0);
    chk("stall_buf_full", 64'(next_valid), 64'd1);
    run(8, 1'b1, 1'b1, 1'b0);

    // Memory not ready for 5 cycles: bubbles
    run(5, 1'b1, 1'b0, 1'b0);
    chk("bubble_valid", 64'(instruction_valid), 64'd0);
    chk("bubble_nop", 64'(instruction), 64'(NOP));
    run(6, 1'b1, 1'b1, 1'b0);

    // Two outstanding, redirect to 0x2002
    run(3, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 64'h2002, 1'b1);
    chk("redir_no_req", 64'(imem_req_valid), 64'd0);
    expect_first_req("redir_req_addr", 64'h2000);
    expect_first_pc("redir_first_pc", 64'h2000);
    run(4, 1'b1, 1'b1, 1'b0);

    // Redirect and stall together while a response arrives
    for (int i = 0; i < 6 && pend.size() == 0; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("rsp_pending", 64'(pend.size() > 0), 64'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 64'h3000, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("rs_nop", 64'(instruction), 64'(NOP));
    chk("rs_valid", 64'(instruction_valid), 64'd0);
    chk("rs_discarded", 64'(next_valid), 64'd0);
    expect_first_pc("rs_first_pc", 64'h3000);

    // Redirect inside DRAIN
    run(3, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 64'h4000, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 64'h5000, 1'b1);
    expect_first_pc("drain_redir_pc", 64'h5000);

    // PC wrap at the top of the address space
    tick(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    expect_first_pc("wrap_first_pc", 64'hFFFF_FFFF_FFFF_FFFC);
    run(8, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of DRAIN with two outstanding
    run(3, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 64'h6000, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("rst2_instruction", 64'(instruction), 64'(NOP));
    chk("rst2_valid", 64'(instruction_valid), 64'd0);
    chk("rst2_pc", instruction_pc, 64'h0);
    chk("rst2_next_valid", 64'(next_valid), 64'd0);
    chk("rst2_idle", 64'(imem_req_valid), 64'd0);
    expect_first_req("rst2_req_addr", 64'h1000);
    expect_first_pc("rst2_first_pc", 64'h1000);
    run(6, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
